// File: rtl/phase_pkg.sv
// Shared types and default timing constants for the intersection phase scheduler.
package phase_pkg;

  localparam int TW_DEF       = 13;
  localparam int GREEN_T_DEF  = 3000;
  localparam int YELLOW_T_DEF = 500;
  localparam int CLEAR_T_DEF  = 200;
  localparam int MAX_EXT_DEF  = 4;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin select: first requester strictly after cur_dir in circular order,
// so the current holder is considered last.
module rr_picker #(
  parameter int N_DIR = 4,
  parameter int DW    = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req,
  input  logic [DW-1:0]    cur_dir,
  output logic             valid,
  output logic [DW-1:0]    idx
);

  logic [DW:0] j;

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int i = N_DIR; i >= 1; i--) begin
      j = {1'b0, cur_dir} + (DW + 1)'(i);
      if (j >= (DW + 1)'(N_DIR)) j = j - (DW + 1)'(N_DIR);
      if (req[j[DW-1:0]]) begin
        valid = 1'b1;
        idx   = j[DW-1:0];
      end
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// N-approach green/yellow/all-red sequencer driving a shared countdown timer.
// Optional cap on green extensions: define PHASE_MAXGREEN_EN.
module phase_scheduler
  import phase_pkg::*;
#(
  parameter int            N_DIR    = 4,
  parameter int            TW       = TW_DEF,
  parameter logic [TW-1:0] GREEN_T  = TW'(GREEN_T_DEF),
  parameter logic [TW-1:0] YELLOW_T = TW'(YELLOW_T_DEF),
  parameter logic [TW-1:0] CLEAR_T  = TW'(CLEAR_T_DEF),
  parameter int            MAX_EXT  = MAX_EXT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DIR-1:0]         req,
  input  logic                     timer_done,
  output logic                     timer_reset,
  output logic [TW-1:0]            timer_value,
  output logic [N_DIR-1:0]         green,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         red,
  output logic [$clog2(N_DIR)-1:0] cur_dir
);

  localparam int DW = $clog2(N_DIR);

  if (N_DIR < 2 || N_DIR > 8) begin : g_bad_n_dir
    $error("phase_scheduler: N_DIR must be 2..8");
  end
  if (GREEN_T < 2 || YELLOW_T < 2 || CLEAR_T < 2) begin : g_bad_durations
    $error("phase_scheduler: phase durations must be at least 2");
  end
  if (MAX_EXT < 1) begin : g_bad_max_ext
    $error("phase_scheduler: MAX_EXT must be at least 1");
  end

  phase_e            state_q, state_d;
  logic [DW-1:0]     cur_dir_q, cur_dir_d;
  logic [TW-1:0]     timer_value_q, timer_value_d;
  logic              timer_reset_q, timer_reset_d;
  logic [N_DIR-1:0]  green_q, green_d;
  logic [N_DIR-1:0]  yellow_q, yellow_d;
  logic [N_DIR-1:0]  red_q, red_d;
  logic              expired_q, expired_d;
  logic              guard_q, guard_d;
`ifdef PHASE_MAXGREEN_EN
  localparam int EW = $clog2(MAX_EXT + 1);
  logic [EW-1:0]     ext_cnt_q, ext_cnt_d;
`endif

  logic              pick_valid;
  logic [DW-1:0]     pick_idx;
  logic [N_DIR-1:0]  cur_mask;
  logic              other;
  logic              entry;

  rr_picker #(.N_DIR(N_DIR), .DW(DW)) u_rr_picker (
    .req     (req),
    .cur_dir (cur_dir_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    cur_dir_d     = cur_dir_q;
    timer_value_d = timer_value_q;
    guard_d       = timer_reset_q;
    entry         = 1'b0;
`ifdef PHASE_MAXGREEN_EN
    ext_cnt_d     = ext_cnt_q;
`endif
    cur_mask = N_DIR'(1) << cur_dir_q;
    other    = |(req & ~cur_mask);
    // A stale timer_done is trusted only once the restart has settled.
    expired_d = expired_q | (timer_done & ~timer_reset_q & ~guard_q);

    case (state_q)
      ALL_RED: begin
        if (expired_q && pick_valid) begin
          state_d       = GREEN;
          cur_dir_d     = pick_idx;
          timer_value_d = GREEN_T;
          entry         = 1'b1;
`ifdef PHASE_MAXGREEN_EN
          ext_cnt_d     = '0;
`endif
        end
      end
      GREEN: begin
        if (expired_q) begin
          if (other) begin
            state_d       = YELLOW;
            timer_value_d = YELLOW_T;
            entry         = 1'b1;
          end else if (req[cur_dir_q]) begin
`ifdef PHASE_MAXGREEN_EN
            if (ext_cnt_q < EW'(MAX_EXT)) begin
              timer_value_d = GREEN_T;
              ext_cnt_d     = ext_cnt_q + 1'b1;
            end else begin
              state_d       = YELLOW;
              timer_value_d = YELLOW_T;
            end
`else
            timer_value_d = GREEN_T;
`endif
            entry = 1'b1;
          end
        end
      end
      YELLOW: begin
        if (expired_q) begin
          state_d       = ALL_RED;
          timer_value_d = CLEAR_T;
          entry         = 1'b1;
        end
      end
      default: begin
        state_d       = ALL_RED;
        timer_value_d = CLEAR_T;
        entry         = 1'b1;
      end
    endcase

    timer_reset_d = entry;
    if (entry) expired_d = 1'b0;

    green_d  = (state_d == GREEN)  ? (N_DIR'(1) << cur_dir_d) : '0;
    yellow_d = (state_d == YELLOW) ? (N_DIR'(1) << cur_dir_d) : '0;
    red_d    = ~(green_d | yellow_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ALL_RED;
      cur_dir_q     <= DW'(N_DIR - 1);
      timer_value_q <= CLEAR_T;
      timer_reset_q <= 1'b1;
      green_q       <= '0;
      yellow_q      <= '0;
      red_q         <= '1;
      expired_q     <= 1'b0;
      guard_q       <= 1'b0;
`ifdef PHASE_MAXGREEN_EN
      ext_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cur_dir_q     <= cur_dir_d;
      timer_value_q <= timer_value_d;
      timer_reset_q <= timer_reset_d;
      green_q       <= green_d;
      yellow_q      <= yellow_d;
      red_q         <= red_d;
      expired_q     <= expired_d;
      guard_q       <= guard_d;
`ifdef PHASE_MAXGREEN_EN
      ext_cnt_q     <= ext_cnt_d;
`endif
    end
  end

  assign timer_reset = timer_reset_q;
  assign timer_value = timer_value_q;
  assign green       = green_q;
  assign yellow      = yellow_q;
  assign red         = red_q;
  assign cur_dir     = cur_dir_q;

endmodule
